mms_stream: RTL and testbench



---
 rtl/mms_pkg.sv | 12 +
 rtl/mms_cmp.sv | 16 +
 rtl/mms_stream.sv | 102 ++++++++++
 tb/tb_mms_stream.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mms_pkg.sv
// Shared definitions for the streaming min/max selector: FSM encoding and mode constants.
package mms_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic MMS_MIN = 1'b1;
  localparam logic MMS_MAX = 1'b0;

endpackage

// File: rtl/mms_cmp.sv
// Strict comparator: better is high when a beats b under the given mode (min or max).
module mms_cmp
  import mms_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             better
);

  // Strict inequality so that equal values never displace the incumbent.
  assign better = (mode == MMS_MIN) ? (a < b) : (a > b);

endmodule

// File: rtl/mms_stream.sv
// Streaming per-batch min/max selector over COUNT unsigned samples.
// Define MMS_STREAM_INDEX_EN to add the winner-position register and the out_index port.
module mms_stream
  import mms_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COUNT = 8,
  localparam int IDX_W = $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
`ifdef MMS_STREAM_INDEX_EN
  output logic [IDX_W-1:0] out_index,
`endif
  output logic             busy
);

  // Handshake: a transfer occurs on a rising edge where valid and ready are both high;
  // ready/valid driven here depend only on registered state, never on the partner's signal.

  localparam logic [IDX_W-1:0] LAST = IDX_W'(COUNT - 1);

  state_t             state;
  logic [IDX_W-1:0]   cnt;
  logic [WIDTH-1:0]   best;
  logic               mode;
  logic               accept;
  logic               better;
  logic               take;
  logic [WIDTH-1:0]   nxt_best;

  mms_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a      (in_data),
    .b      (best),
    .mode   (mode),
    .better (better)
  );

  assign in_ready  = (state == ACCUM) && !reset;
  assign out_valid = (state == DONE);
  assign busy      = (state == DONE) || (cnt != '0);
  assign accept    = in_valid && in_ready;

  // First sample of a batch loads unconditionally; later ones only on a strict win.
  assign take     = (cnt == '0) || better;
  assign nxt_best = take ? in_data : best;

`ifdef MMS_STREAM_INDEX_EN
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W-1:0] nxt_idx;

  assign nxt_idx = take ? cnt : best_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      best_idx  <= '0;
      out_index <= '0;
    end else if (state == ACCUM && accept) begin
      best_idx <= nxt_idx;
      if (cnt == LAST) out_index <= nxt_idx;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ACCUM;
      cnt        <= '0;
      best       <= '0;
      mode       <= MMS_MAX;
      out_result <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            best <= nxt_best;
            if (cnt == '0) mode <= select;
            if (cnt == LAST) begin
              cnt        <= '0;
              out_result <= nxt_best;
              state      <= DONE;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_mms_stream.sv
// Bench for mms_stream: directed batches on an 8x8 instance, random batches on a 12-bit/5-sample instance.
`timescale 1ns/1ps
module tb_mms_stream;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- DUT 8x8 ----------------
  logic       select8 = 1'b0, in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic       in_ready8, out_valid8, busy8;
  logic [7:0] in_data8 = '0, out_result8;
  logic [2:0] out_index8;
  logic [10:0] exp_q8[$];

  mms_stream #(.WIDTH(8), .COUNT(8)) dut8 (
    .clk        (clk),
    .reset      (reset),
    .select     (select8),
    .in_valid   (in_valid8),
    .in_ready   (in_ready8),
    .in_data    (in_data8),
    .out_valid  (out_valid8),
    .out_ready  (out_ready8),
    .out_result (out_result8),
`ifdef MMS_STREAM_INDEX_EN
    .out_index  (out_index8),
`endif
    .busy       (busy8)
  );

`ifndef MMS_STREAM_INDEX_EN
  assign out_index8 = '0;
`endif

  // ---------------- DUT 12-bit x5 ----------------
  logic        select5 = 1'b0, in_valid5 = 1'b0, out_ready5 = 1'b0;
  logic        in_ready5, out_valid5, busy5;
  logic [11:0] in_data5 = '0, out_result5;
  logic [2:0]  out_index5;
  logic [14:0] exp_q5[$];

  mms_stream #(.WIDTH(12), .COUNT(5)) dut5 (
    .clk        (clk),
    .reset      (reset),
    .select     (select5),
    .in_valid   (in_valid5),
    .in_ready   (in_ready5),
    .in_data    (in_data5),
    .out_valid  (out_valid5),
    .out_ready  (out_ready5),
    .out_result (out_result5),
`ifdef MMS_STREAM_INDEX_EN
    .out_index  (out_index5),
`endif
    .busy       (busy5)
  );

`ifndef MMS_STREAM_INDEX_EN
  assign out_index5 = '0;
`endif

  // Reference: first sample wins ties; later samples replace only on strict improvement.
  function automatic logic [14:0] model5(input logic [11:0] s[5], input logic m);
    logic [11:0] bv;
    logic [2:0]  bi;
    bv = s[0];
    bi = 3'd0;
    for (int i = 1; i < 5; i++) begin
      if (m ? (s[i] < bv) : (s[i] > bv)) begin
        bv = s[i];
        bi = 3'(i);
      end
    end
    return {bi, bv};
  endfunction

  // ---------------- drivers ----------------
  task automatic send8(input logic [7:0] d, input logic sel);
    int n;
    n = 0;
    @(negedge clk);
    in_valid8 = 1'b1;
    in_data8  = d;
    select8   = sel;
    while (!in_ready8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready8) begin
      vectors++;
      miscompares++;
      $display("FAIL send8_ready_timeout: in_ready=%0b required 1", in_ready8);
    end
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
  endtask

  task automatic collect8(input string name);
    logic [10:0] e;
    int n;
    n = 0;
    while (!out_valid8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!out_valid8) begin
      miscompares++;
      $display("FAIL %s_valid_timeout: out_valid=%0b required 1", name, out_valid8);
    end else if (exp_q8.size() == 0) begin
      miscompares++;
      $display("FAIL %s_unexpected: result=%0d required no output", name, out_result8);
    end else begin
      e = exp_q8.pop_front();
      if (out_result8 !== e[7:0]) begin
        miscompares++;
        $display("FAIL %s_result: got %0d required %0d", name, out_result8, e[7:0]);
      end
`ifdef MMS_STREAM_INDEX_EN
      vectors++;
      if (out_index8 !== e[10:8]) begin
        miscompares++;
        $display("FAIL %s_index: got %0d required %0d", name, out_index8, e[10:8]);
      end
`endif
      out_ready8 = 1'b1;
      @(posedge clk);
      #1;
      out_ready8 = 1'b0;
      vectors++;
      if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_after_take: out_valid=%0b in_ready=%0b required 0 1", name, out_valid8, in_ready8);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (in_ready8 !== 1'b0 || in_ready5 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready_low: got %0b/%0b required 0/0", in_ready8, in_ready5);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: in_ready=%0b out_valid=%0b busy=%0b required 1 0 0", in_ready8, out_valid8, busy8);
    end
    vectors++;
    if (out_result8 !== 8'd0 || out_index8 !== 3'd0 || out_valid5 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: result=%0d index=%0d valid5=%0b required 0 0 0", out_result8, out_index8, out_valid5);
    end
  endtask

  task automatic test_min();
    logic [7:0] s[8];
    s = '{8'd5, 8'd9, 8'd3, 8'd200, 8'd3, 8'd7, 8'd255, 8'd1};
    exp_q8.push_back({3'd7, 8'd1});
    for (int i = 0; i < 7; i++) send8(s[i], 1'b1);
    vectors++;
    if (out_valid8 !== 1'b0 || busy8 !== 1'b1) begin
      miscompares++;
      $display("FAIL min_early_valid: out_valid=%0b busy=%0b required 0 1", out_valid8, busy8);
    end
    send8(s[7], 1'b1);
    vectors++;
    if (out_valid8 !== 1'b1) begin
      miscompares++;
      $display("FAIL min_latency: out_valid=%0b required 1", out_valid8);
    end
    collect8("min");
  endtask

  task automatic test_max();
    logic [7:0] s[8];
    s = '{8'd5, 8'd9, 8'd3, 8'd200, 8'd3, 8'd7, 8'd255, 8'd1};
    exp_q8.push_back({3'd6, 8'd255});
    for (int i = 0; i < 8; i++) send8(s[i], 1'b0);
    collect8("max");
  endtask

  task automatic test_ties();
    exp_q8.push_back({3'd0, 8'd4});
    for (int i = 0; i < 8; i++) send8(8'd4, 1'b0);
    collect8("ties_max");
    exp_q8.push_back({3'd0, 8'd4});
    for (int i = 0; i < 8; i++) send8(8'd4, 1'b1);
    collect8("ties_min");
  endtask

  task automatic test_backpressure();
    logic [7:0] s[8];
    s = '{8'd20, 8'd30, 8'd25, 8'd11, 8'd40, 8'd11, 8'd90, 8'd60};
    exp_q8.push_back({3'd3, 8'd11});
    for (int i = 0; i < 8; i++) send8(s[i], 1'b1);
    @(negedge clk);
    in_valid8 = 1'b1;
    in_data8  = 8'd0;
    select8   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (in_ready8 !== 1'b0 || out_valid8 !== 1'b1 || out_result8 !== 8'd11) begin
        miscompares++;
        $display("FAIL stall_hold: in_ready=%0b out_valid=%0b result=%0d required 0 1 11", in_ready8, out_valid8, out_result8);
      end
    end
    collect8("stall");
    // in_valid is still high with sample 0: it must be taken as the first of the next batch.
    exp_q8.push_back({3'd0, 8'd0});
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    vectors++;
    if (busy8 !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_restart_busy: busy=%0b required 1", busy8);
    end
    for (int i = 0; i < 7; i++) send8(8'(15 + 3 * i), 1'b1);
    collect8("stall_next");
  endtask

  task automatic test_select_toggle();
    logic [7:0] s[8];
    s = '{8'd10, 8'd2, 8'd30, 8'd40, 8'd5, 8'd60, 8'd70, 8'd80};
    exp_q8.push_back({3'd1, 8'd2});
    for (int i = 0; i < 8; i++) send8(s[i], (i < 3) ? 1'b1 : 1'b0);
    collect8("select_toggle");
  endtask

  task automatic test_reset_mid();
    logic [7:0] s[8];
    s = '{8'd200, 8'd150, 8'd180, 8'd150, 8'd220, 8'd199, 8'd160, 8'd210};
    for (int i = 0; i < 4; i++) send8(8'(9 - i), 1'b1);
    vectors++;
    if (busy8 !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_busy_before: busy=%0b required 1", busy8);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (out_valid8 !== 1'b0 || busy8 !== 1'b0 || out_result8 !== 8'd0) begin
      miscompares++;
      $display("FAIL midreset_cleared: out_valid=%0b busy=%0b result=%0d required 0 0 0", out_valid8, busy8, out_result8);
    end
    exp_q8.push_back({3'd4, 8'd220});
    for (int i = 0; i < 4; i++) send8(s[i], 1'b0);
    vectors++;
    if (out_valid8 !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_stale_batch: out_valid=%0b required 0", out_valid8);
    end
    for (int i = 4; i < 8; i++) send8(s[i], 1'b0);
    collect8("midreset_fresh");
  endtask

  task automatic test_back_to_back();
    logic [7:0] a[8];
    logic [7:0] b[8];
    logic [10:0] e;
    int d;
    int n;
    a = '{8'd50, 8'd60, 8'd40, 8'd40, 8'd90, 8'd45, 8'd41, 8'd70};
    b = '{8'd3, 8'd17, 8'd17, 8'd9, 8'd0, 8'd17, 8'd2, 8'd1};
    exp_q8.push_back({3'd2, 8'd40});
    exp_q8.push_back({3'd1, 8'd17});
    out_ready8 = 1'b1;
    d = 0;
    fork
      begin
        int c0;
        c0 = cyc;
        for (int i = 0; i < 8; i++) send8(a[i], 1'b1);
        for (int i = 0; i < 8; i++) send8(b[i], 1'b0);
        d = cyc - c0;
      end
      begin
        for (int k = 0; k < 2; k++) begin
          n = 0;
          @(negedge clk);
          while (!out_valid8 && n < 40) begin
            @(negedge clk);
            n++;
          end
          vectors++;
          if (!out_valid8) begin
            miscompares++;
            $display("FAIL b2b_valid_timeout: out_valid=%0b required 1", out_valid8);
          end else begin
            e = exp_q8.pop_front();
            if (out_result8 !== e[7:0]) begin
              miscompares++;
              $display("FAIL b2b_result: got %0d required %0d", out_result8, e[7:0]);
            end
`ifdef MMS_STREAM_INDEX_EN
            vectors++;
            if (out_index8 !== e[10:8]) begin
              miscompares++;
              $display("FAIL b2b_index: got %0d required %0d", out_index8, e[10:8]);
            end
`endif
            @(posedge clk);
          end
        end
      end
    join
    out_ready8 = 1'b0;
    vectors++;
    if (d !== 17) begin
      miscompares++;
      $display("FAIL b2b_period: 16 accepts took %0d cycles required 17", d);
    end
  endtask

  task automatic test_random();
    fork
      begin
        logic [11:0] s[5];
        logic        m;
        int          n;
        for (int b = 0; b < 1000; b++) begin
          m = 1'($urandom_range(0, 1));
          for (int i = 0; i < 5; i++)
            s[i] = 12'($urandom_range(0, (b % 2 == 0) ? 4095 : 7));
          exp_q5.push_back(model5(s, m));
          for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 2) == 0) begin
              repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                in_valid5 = 1'b0;
                in_data5  = 12'($urandom_range(0, 4095));
                select5   = 1'($urandom_range(0, 1));
              end
            end
            @(negedge clk);
            in_valid5 = 1'b1;
            in_data5  = s[i];
            select5   = (i == 0) ? m : 1'($urandom_range(0, 1));
            n = 0;
            while (!in_ready5 && n < 100) begin
              @(negedge clk);
              n++;
            end
            if (!in_ready5) begin
              vectors++;
              miscompares++;
              $display("FAIL rand_ready_timeout: in_ready=%0b required 1", in_ready5);
            end
            @(posedge clk);
            #1;
            in_valid5 = 1'b0;
          end
        end
      end
      begin
        logic [14:0] e;
        int got;
        int guard;
        got = 0;
        guard = 0;
        while (got < 1000 && guard < 60000) begin
          @(negedge clk);
          guard++;
          out_ready5 = ($urandom_range(0, 3) != 0);
          if (out_valid5 && out_ready5) begin
            got++;
            vectors++;
            if (exp_q5.size() == 0) begin
              miscompares++;
              $display("FAIL rand_unexpected: result=%0d required no output", out_result5);
            end else begin
              e = exp_q5.pop_front();
              if (out_result5 !== e[11:0]) begin
                miscompares++;
                $display("FAIL rand_result batch %0d: got %0d required %0d", got, out_result5, e[11:0]);
              end
`ifdef MMS_STREAM_INDEX_EN
              vectors++;
              if (out_index5 !== e[14:12]) begin
                miscompares++;
                $display("FAIL rand_index batch %0d: got %0d required %0d", got, out_index5, e[14:12]);
              end
`endif
            end
          end
        end
        vectors++;
        if (got != 1000) begin
          miscompares++;
          $display("FAIL rand_timeout: got %0d results required 1000", got);
        end
        @(negedge clk);
        out_ready5 = 1'b0;
      end
    join
  endtask

  task automatic test_drain();
    vectors++;
    if (exp_q8.size() != 0 || exp_q5.size() != 0) begin
      miscompares++;
      $display("FAIL drain: pending %0d/%0d required 0/0", exp_q8.size(), exp_q5.size());
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_min();
    test_max();
    test_ties();
    test_backpressure();
    test_select_toggle();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
